// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Entry layout, FIFO depth and PC stepping live here.
package fetch_pkg;

    localparam int FETCH_ADDR_W     = 32;
    localparam int FETCH_INSTR_W    = 48;
    localparam int FETCH_FIFO_DEPTH = 2;
    localparam int FETCH_CNT_W      = $clog2(FETCH_FIFO_DEPTH + 1);
    localparam int FETCH_PC_STEP    = 4;

    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer for fetched {pc, instr} entries.
// Flush and reset empty it; head is the oldest entry.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int W = FETCH_ADDR_W + FETCH_INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [FETCH_CNT_W-1:0] count
);

    logic [W-1:0] mem [FETCH_FIFO_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;

    assign head = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush drops everything held.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + FETCH_CNT_W'(push) - FETCH_CNT_W'(pop);
        end
    end

    // Storage has no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and ROM read master feeding decode over valid/ready.
// Issues a read only when the skid FIFO can absorb its response.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
    parameter int                PC_STEP  = FETCH_PC_STEP
) (
    input  logic               CLK,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  Rom_Address,
    input  logic [INSTR_W-1:0] Rom_Instr,
    output logic               If_Valid,
    input  logic               If_Ready,
    output logic [ADDR_W-1:0]  If_Pc,
    output logic [INSTR_W-1:0] If_Instr,
    input  logic               Redirect_Valid,
    input  logic [ADDR_W-1:0]  Redirect_Pc
);

    localparam int E = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]      fetch_pc;
    logic [ADDR_W-1:0]      req_pc_q;
    logic                   req_valid_q;
    logic [ADDR_W-1:0]      redirect_target;
    logic                   rsp_valid;
    logic [E-1:0]           rsp_data;
    logic [E-1:0]           head;
    logic [FETCH_CNT_W-1:0] count;
    logic [FETCH_CNT_W:0]   count_next;
    logic                   fifo_busy;
    logic                   pop;
    logic                   fifo_pop;
    logic                   push;
    logic                   issue;

    assign redirect_target = Redirect_Pc & ~ADDR_W'(3);
    assign Rom_Address = Redirect_Valid ? redirect_target : fetch_pc;

    assign rsp_valid = req_valid_q && !Redirect_Valid;
    assign rsp_data  = {req_pc_q, Rom_Instr};
    assign fifo_busy = (count != '0);

    assign If_Valid = !Reset && !Redirect_Valid && (fifo_busy || rsp_valid);
    assign {If_Pc, If_Instr} = fifo_busy ? head : rsp_data;

    assign pop      = If_Valid && If_Ready;
    assign fifo_pop = pop && fifo_busy;
    assign push     = rsp_valid && !Reset && !(!fifo_busy && pop);

    // Occupancy after this cycle decides whether a new read fits.
    always_comb begin
        count_next = '0;
        if (!Redirect_Valid) begin
            count_next = {1'b0, count}
                       + (FETCH_CNT_W + 1)'(push)
                       - (FETCH_CNT_W + 1)'(fifo_pop);
        end
    end

    assign issue = !Reset && (count_next <= (FETCH_CNT_W + 1)'(1));

    // PC advance and in-flight read tracking.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_pc    <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else if (issue) begin
            req_valid_q <= 1'b1;
            req_pc_q    <= Rom_Address;
            fetch_pc    <= Rom_Address + ADDR_W'(PC_STEP);
        end else begin
            req_valid_q <= 1'b0;
        end
    end

    fetch_skid_fifo #(
        .W(E)
    ) u_fifo (
        .clk   (CLK),
        .rst   (Reset),
        .push  (push),
        .pop   (fifo_pop),
        .flush (Redirect_Valid),
        .din   (rsp_data),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 1-cycle ROM.
// Cycle table plus hand sequences for wrap and mid-stream reset.
module tb_instruction_fetch_unit;

    localparam logic [47:0] W0 = 48'hE04002000000;
    localparam logic [47:0] W1 = 48'hE14004000001;
    localparam logic [47:0] W2 = 48'hE14008000001;
    localparam logic [47:0] W3 = 48'hE03106000002;
    localparam logic [47:0] W4 = 48'hBEEF00000004;
    localparam logic [47:0] WT = 48'hBEEF000003FF;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [47:0] rom_q;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [47:0] if_instr;
    logic        rv;
    logic [31:0] rpc;

    logic [47:0] rom [1024];

    int n_chk;
    int n_fail;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [47:0] ei;
        logic        ca;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];

    instruction_fetch_unit dut (
        .CLK            (clk),
        .Reset          (rst),
        .Rom_Address    (rom_addr),
        .Rom_Instr      (rom_q),
        .If_Valid       (if_valid),
        .If_Ready       (if_ready),
        .If_Pc          (if_pc),
        .If_Instr       (if_instr),
        .Redirect_Valid (rv),
        .Redirect_Pc    (rpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr[11:2]];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic v,
                       input logic [31:0] p, input logic ev,
                       input logic [31:0] epc, input logic [47:0] ei,
                       input logic ca, input logic [31:0] ea);
        vec_t x;
        x.rst = r; x.rdy = rdy; x.rv = v; x.rpc = p;
        x.ev = ev; x.epc = epc; x.ei = ei; x.ca = ca; x.ea = ea;
        tbl.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic v,
                       input logic [31:0] p);
        @(posedge clk);
        #1;
        rst = r; if_ready = rdy; rv = v; rpc = p;
        @(negedge clk);
    endtask

    task automatic see(input string n, input logic ev,
                       input logic [31:0] epc, input logic [47:0] ei);
        chk({n, " valid"}, 64'(if_valid), 64'(ev));
        if (ev) begin
            chk({n, " pc"}, 64'(if_pc), 64'(epc));
            chk({n, " instr"}, 64'(if_instr), 64'(ei));
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        if_ready = 1'b1;
        rv = 1'b0;
        rpc = '0;
        for (int i = 0; i < 1024; i++) rom[i] = {16'hBEEF, 32'(i)};
        rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = W3;

        // reset then stream 0,4,8,C
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 0, 1, 32'h0, W0, 1, 32'h4);
        add(0, 1, 0, 0, 1, 32'h4, W1, 1, 32'h8);
        add(0, 1, 0, 0, 1, 32'h8, W2, 1, 32'hC);
        add(0, 1, 0, 0, 1, 32'hC, W3, 1, 32'h10);
        // stall with PC 4 held for 4 cycles
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 0, 1, 32'h0, W0, 1, 32'h4);
        add(0, 0, 0, 0, 1, 32'h4, W1, 1, 32'h8);
        add(0, 0, 0, 0, 1, 32'h4, W1, 1, 32'hC);
        add(0, 0, 0, 0, 1, 32'h4, W1, 1, 32'hC);
        add(0, 0, 0, 0, 1, 32'h4, W1, 1, 32'hC);
        add(0, 1, 0, 0, 1, 32'h4, W1, 1, 32'hC);
        add(0, 1, 0, 0, 1, 32'h8, W2, 1, 32'h10);
        add(0, 1, 0, 0, 1, 32'hC, W3, 1, 32'h14);
        // redirect to C while PC 4 would be presented
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 0, 1, 32'h0, W0, 1, 32'h4);
        add(0, 1, 1, 32'hC, 0, 0, 0, 1, 32'hC);
        add(0, 1, 0, 0, 1, 32'hC, W3, 1, 32'h10);
        add(0, 1, 0, 0, 1, 32'h10, W4, 1, 32'h14);
        // misaligned redirect target
        add(0, 1, 1, 32'h6, 0, 0, 0, 1, 32'h4);
        add(0, 1, 0, 0, 1, 32'h4, W1, 1, 32'h8);
        // redirect while stalled
        add(0, 0, 0, 0, 1, 32'h8, W2, 0, 0);
        add(0, 0, 0, 0, 1, 32'h8, W2, 0, 0);
        add(0, 0, 1, 32'h0, 0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 0, 1, 32'h0, W0, 1, 32'h4);
        add(0, 1, 0, 0, 1, 32'h4, W1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            see($sformatf("row%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei);
            if (tbl[i].ca)
                chk($sformatf("row%0d addr", i), 64'(rom_addr),
                    64'(tbl[i].ea));
        end

        // wrap at top of address space
        cyc(0, 1, 1, 32'hFFFF_FFFF);
        see("wrap redir", 0, 0, 0);
        chk("wrap redir addr", 64'(rom_addr), 64'h0000_0000_FFFF_FFFC);
        cyc(0, 1, 0, 0);
        see("wrap top", 1, 32'hFFFF_FFFC, WT);
        chk("wrap addr", 64'(rom_addr), 64'h0);
        cyc(0, 1, 0, 0);
        see("wrap zero", 1, 32'h0, W0);

        // fill FIFO, then reset mid-stream
        cyc(0, 0, 0, 0);
        see("fill a", 1, 32'h4, W1);
        cyc(0, 0, 0, 0);
        see("fill b", 1, 32'h4, W1);
        chk("fill frozen addr", 64'(rom_addr), 64'hC);
        cyc(1, 1, 0, 0);
        see("mid rst", 0, 0, 0);
        cyc(0, 1, 0, 0);
        see("post rst", 0, 0, 0);
        chk("post rst addr", 64'(rom_addr), 64'h0);
        cyc(0, 1, 0, 0);
        see("restart 0", 1, 32'h0, W0);
        cyc(0, 1, 0, 0);
        see("restart 4", 1, 32'h4, W1);
        cyc(0, 1, 0, 0);
        see("restart 8", 1, 32'h8, W2);
        cyc(0, 1, 0, 0);
        see("restart C", 1, 32'hC, W3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
